// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared state encoding and result packing for the serial magnitude compare
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPARE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    // Result encodings when packed as {gt, eq, lt}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    function automatic logic [2:0] pack_res(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/serial_mag_cmp_ctrl_if.sv
// rtl/serial_mag_cmp_ctrl_if.sv - request/result bundle of the serial magnitude compare
// master: drives start/a/b, observes busy/done/eq/gt/lt/bits_used
// slave : the compare controller
interface serial_mag_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CW-1:0]    bits_used;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt, bits_used
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt, bits_used
    );

endinterface

// File: rtl/bit_cmp_slice.sv
// rtl/bit_cmp_slice.sv - stateless 1-bit magnitude compare slice
// x, y  : bits under comparison
// E     : x == y,  not_E : x != y
// G     : x > y,   L     : x < y
module bit_cmp_slice (
    input  logic x,
    input  logic y,
    output logic E,
    output logic not_E,
    output logic G,
    output logic L
);

    assign E     = ~(x ^ y);
    assign not_E = x ^ y;
    assign G     = x & ~y;
    assign L     = ~x & y;

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// rtl/serial_mag_cmp_ctrl.sv - MSB-first bit-serial unsigned magnitude compare sequencer
// clk, rst_n : clock, asynchronous active-low reset
// bus.start/a/b        : request and operands, taken only in IDLE
// bus.busy             : high in COMPARE and DONE
// bus.done             : one-cycle pulse, result valid and held afterwards
// bus.eq/gt/lt         : registered result
// bus.bits_used        : bit positions examined, 1..WIDTH
module serial_mag_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_mag_cmp_ctrl_if.slave  bus
);
    import serial_cmp_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    bits_q, bits_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             done_q, done_d;

    logic sl_e, sl_g, sl_l;
    logic sl_not_e_unused;

    bit_cmp_slice u_slice (
        .x     (ra_q[idx_q]),
        .y     (rb_q[idx_q]),
        .E     (sl_e),
        .not_E (sl_not_e_unused),
        .G     (sl_g),
        .L     (sl_l)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    idx_d   = IDX_MSB;
                    cnt_d   = '0;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (sl_g || sl_l) begin
                    // First differing bit decides the result.
                    gt_d    = sl_g;
                    lt_d    = sl_l;
                    eq_d    = 1'b0;
                    bits_d  = cnt_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (sl_e && idx_q == '0) begin
                    // Last bit also matched: operands equal; idx never steps below 0.
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    bits_d  = CNT_MAX;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q == ST_COMPARE) || (state_q == ST_DONE);
    assign bus.done      = done_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.bits_used = bits_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// tb/tb_serial_mag_cmp_ctrl.sv - self-checking bench for serial_mag_cmp_ctrl
module tb_serial_mag_cmp_ctrl;
    import serial_cmp_pkg::*;

    localparam int WIDTH  = 8;
    localparam int BUDGET = WIDTH + 6;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       res;
        int               bits;
        int               lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_mag_cmp_ctrl_if #(.WIDTH(WIDTH)) cmp_if ();

    serial_mag_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cmp_if)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    vec_t sb_q[$];
    vec_t vecs[8];

    always @(posedge clk) begin
        #1;
        if (cmp_if.done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] cur_res();
        return pack_res(cmp_if.gt, cmp_if.eq, cmp_if.lt);
    endfunction

    // Expected outcome from the highest differing bit.
    function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        vec_t v;
        v = '{a, b, RES_EQ, WIDTH, WIDTH + 1};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                v.res  = a[i] ? RES_GT : RES_LT;
                v.bits = WIDTH - i;
                v.lat  = WIDTH - i + 1;
                return v;
            end
        end
        return v;
    endfunction

    // Called #1 after an edge; returns edges until done is seen high.
    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (cmp_if.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // pre = edges already elapsed since the accepting edge. Latency counts up to
    // the edge that samples done, hence the +1.
    task automatic finish_cmp(input int pre, input string tag);
        int   n;
        bit   ok;
        vec_t e;
        wait_done(n, ok);
        check({tag, " done_seen"}, 32'(ok), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            if (ok) begin
                check({tag, " result"}, 32'(cur_res()), 32'(e.res));
                check({tag, " bits_used"}, 32'(cmp_if.bits_used), 32'(e.bits));
                check({tag, " latency"}, 32'(pre + n + 1), 32'(e.lat));
                check({tag, " busy_in_done"}, 32'(cmp_if.busy), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(cmp_if.done), 32'd0);
        check({tag, " idle_after"}, 32'(cmp_if.busy), 32'd0);
    endtask

    task automatic do_cmp(input vec_t e, input string tag);
        sb_q.push_back(e);
        cmp_if.a     = e.a;
        cmp_if.b     = e.b;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        check({tag, " busy_after_start"}, 32'(cmp_if.busy), 32'd1);
        finish_cmp(0, tag);
    endtask

    initial begin
        int d0;
        int n;
        bit ok;
        logic [WIDTH-1:0] ra, rb;

        vecs[0] = '{8'hA5, 8'h25, RES_GT, 1, 2};
        vecs[1] = '{8'h3C, 8'h3D, RES_LT, 8, 9};
        vecs[2] = '{8'hFF, 8'hFF, RES_EQ, 8, 9};
        vecs[3] = '{8'h00, 8'h00, RES_EQ, 8, 9};
        vecs[4] = '{8'h80, 8'h7F, RES_GT, 1, 2};
        vecs[5] = '{8'h01, 8'h00, RES_GT, 8, 9};
        vecs[6] = '{8'h40, 8'h7F, RES_LT, 3, 4};
        vecs[7] = '{8'h7F, 8'h80, RES_LT, 1, 2};

        cmp_if.start = 1'b0;
        cmp_if.a     = '0;
        cmp_if.b     = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", 32'(cur_res()), 32'(RES_NONE));
        check("reset busy", 32'(cmp_if.busy), 32'd0);
        check("reset done", 32'(cmp_if.done), 32'd0);
        check("reset bits_used", 32'(cmp_if.bits_used), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) do_cmp(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            do_cmp(model(ra, rb), $sformatf("rnd%0d", i));
        end

        // Second start while busy, with new operands, must be ignored.
        d0 = done_cnt;
        sb_q.push_back(vecs[0]);
        sb_q[sb_q.size() - 1] = '{8'h10, 8'h01, RES_GT, 4, 5};
        cmp_if.a     = 8'h10;
        cmp_if.b     = 8'h01;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.a     = 8'h00;
        cmp_if.b     = 8'hFF;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        finish_cmp(1, "busy_start");
        repeat (12) @(posedge clk);
        #1;
        check("busy_start single_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start no_restart", 32'(cmp_if.busy), 32'd0);

        // Start during DONE is dropped; start the cycle after done is taken.
        sb_q.push_back('{8'h25, 8'hA5, RES_LT, 1, 2});
        cmp_if.a     = 8'h25;
        cmp_if.b     = 8'hA5;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        wait_done(n, ok);
        check("b2b first done_seen", 32'(ok), 32'd1);
        void'(sb_q.pop_front());
        check("b2b first result", 32'(cur_res()), 32'(RES_LT));
        cmp_if.a     = 8'h00;
        cmp_if.b     = 8'hFF;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        check("start_in_done ignored", 32'(cmp_if.busy), 32'd0);
        sb_q.push_back('{8'h80, 8'h7F, RES_GT, 1, 2});
        cmp_if.a     = 8'h80;
        cmp_if.b     = 8'h7F;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        check("b2b accepted", 32'(cmp_if.busy), 32'd1);
        check("b2b result_held", 32'(cur_res()), 32'(RES_LT));
        finish_cmp(0, "b2b second");

        // Asynchronous reset three edges into a compare.
        cmp_if.a     = 8'h00;
        cmp_if.b     = 8'h01;
        cmp_if.start = 1'b1;
        @(posedge clk);
        #1;
        cmp_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort busy_before", 32'(cmp_if.busy), 32'd1);
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort result", 32'(cur_res()), 32'(RES_NONE));
        check("abort busy", 32'(cmp_if.busy), 32'd0);
        check("abort done", 32'(cmp_if.done), 32'd0);
        check("abort bits_used", 32'(cmp_if.bits_used), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort no_done", 32'(done_cnt - d0), 32'd0);
        do_cmp('{8'h00, 8'h01, RES_LT, 8, 9}, "after_abort");

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
